// File: rtl/pong_btn_conditioner.sv
// Purpose: synchronise and debounce the raw paddle buttons; emit clean levels plus press/release/any_press pulses.
// Latency: btn_level and its pulses change DEBOUNCE_CYCLES+1 edges after the edge that first samples a stable btn_raw.
// Backpressure: none; outputs are free-running registered levels and one-cycle pulses.
module pong_btn_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // STABLE: synchronised input agrees with the debounced level.
  // PENDING: it disagrees and the stability counter is running.
  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } btn_state_e;

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic             any_q, any_d;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];
  btn_state_e       state [N_BTN];

  // Two-flop synchroniser; nothing between the flops so metastability has a full cycle to settle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-button state is implied by whether the synchronised input differs from the held level.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state[i] = (sync2_q[i] != level_q[i]) ? PENDING : STABLE;
    end
  end

  // Next-state: count while pending, commit the new level on the terminal count, clear on any bounce.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      case (state[i])
        STABLE: cnt_d[i] = '0;
        PENDING: begin
          if (cnt_q[i] == CNT_MAX) begin
            level_d[i]   = sync2_q[i];
            press_d[i]   = sync2_q[i];
            release_d[i] = ~sync2_q[i];
            cnt_d[i]     = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: cnt_d[i] = '0;
      endcase
    end
    any_d = |press_d;
  end

  // Debounce state and registered pulses; pulses land on the same edge that flips the level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign any_press   = any_q;

endmodule

// File: tb/tb_pong_btn_conditioner.sv
// Bench for pong_btn_conditioner with a short debounce window.
// A reference model decides each edge from the last D synchronised samples of every button.
// Directed scenarios check latency and pulse shapes; a random phase stresses bounces and resets.
module tb_pong_btn_conditioner;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic         any_press;

  int n_cmp  = 0;
  int n_fail = 0;

  pong_btn_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  always #5 clk = ~clk;

  // Reference model: hist holds the raw value sampled at each of the last D+1 edges
  // (zeros stand in for the cleared synchroniser after reset).
  logic [N-1:0] hist[$];
  logic [N-1:0] m_lvl, m_prs, m_rel;
  logic         m_any;

  task automatic model_reset();
    hist.delete();
    repeat (D + 1) hist.push_back('0);
    m_lvl = '0; m_prs = '0; m_rel = '0; m_any = 1'b0;
  endtask

  // A button flips when its synchronised value has differed from the level for D consecutive edges.
  task automatic model_edge(input logic [N-1:0] raw);
    if (!reset) begin
      model_reset();
      return;
    end
    m_prs = '0;
    m_rel = '0;
    for (int b = 0; b < N; b++) begin
      logic v;
      logic same;
      v = hist[hist.size() - 2][b];
      same = 1'b1;
      for (int k = hist.size() - 1 - D; k <= hist.size() - 2; k++)
        if (hist[k][b] != v) same = 1'b0;
      if (same && v != m_lvl[b]) begin
        m_lvl[b] = v;
        if (v) m_prs[b] = 1'b1;
        else   m_rel[b] = 1'b1;
      end
    end
    m_any = |m_prs;
    hist.push_back(raw);
    while (hist.size() > D + 1) void'(hist.pop_front());
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".level"},   32'(btn_level),   32'(m_lvl));
    chk({tag, ".press"},   32'(btn_press),   32'(m_prs));
    chk({tag, ".release"}, 32'(btn_release), 32'(m_rel));
    chk({tag, ".any"},     32'(any_press),   32'(m_any));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".level0"},   32'(btn_level),   32'd0);
    chk({tag, ".press0"},   32'(btn_press),   32'd0);
    chk({tag, ".release0"}, 32'(btn_release), 32'd0);
    chk({tag, ".any0"},     32'(any_press),   32'd0);
  endtask

  // One clock: drive raw between edges, advance the model at the edge, compare just after it.
  task automatic step(input logic [N-1:0] raw, input string tag);
    btn_raw = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    chk_model(tag);
  endtask

  // Hold raw and report on which step (1 = edge that first samples it) a pulse in mask appears.
  task automatic hold_until(input logic [N-1:0] raw, input logic [N-1:0] mask, input bit rel,
                            input string tag, output int at, output logic [N-1:0] vec,
                            output logic anyv);
    at = 99; vec = '0; anyv = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step(raw, tag);
      if (at == 99 && (((rel ? btn_release : btn_press) & mask) != '0)) begin
        at = k;
        vec = rel ? btn_release : btn_press;
        anyv = any_press;
      end
    end
  endtask

  initial begin
    int at;
    logic [N-1:0] vec;
    logic anyv;
    logic [N-1:0] raw;
    int hold;

    model_reset();

    // 1: buttons held through reset
    btn_raw = 4'hF;
    #1;
    chk_zero("t1_rst");
    repeat (3) step(4'hF, "t1_inrst");
    reset = 1'b1;
    hold_until(4'hF, 4'hF, 1'b0, "t1", at, vec, anyv);
    chk("t1_latency", 32'(at), 32'd6);
    chk("t1_pressvec", 32'(vec), 32'hF);
    chk("t1_any", 32'(anyv), 32'd1);
    chk("t1_level", 32'(btn_level), 32'hF);
    repeat (10) step(4'h0, "t1_clear");

    // 2: single press on button 0
    hold_until(4'h1, 4'h1, 1'b0, "t2", at, vec, anyv);
    chk("t2_latency", 32'(at), 32'd6);
    chk("t2_pressvec", 32'(vec), 32'h1);

    // 3: bouncing button 2, then settles high
    for (int r = 0; r < 2; r++) begin
      repeat (2) step(4'h5, "t3_bounce");
      repeat (2) step(4'h1, "t3_bounce");
    end
    hold_until(4'h5, 4'h4, 1'b0, "t3", at, vec, anyv);
    chk("t3_latency", 32'(at), 32'd6);
    chk("t3_pressvec", 32'(vec), 32'h4);

    // 4: buttons 1 and 3 together
    hold_until(4'hF, 4'hA, 1'b0, "t4", at, vec, anyv);
    chk("t4_latency", 32'(at), 32'd6);
    chk("t4_pressvec", 32'(vec), 32'hA);
    chk("t4_any", 32'(anyv), 32'd1);

    // 5: release of button 3
    hold_until(4'h7, 4'h8, 1'b1, "t5", at, vec, anyv);
    chk("t5_latency", 32'(at), 32'd6);
    chk("t5_relvec", 32'(vec), 32'h8);
    chk("t5_any", 32'(anyv), 32'd0);

    // 6: reset mid-count on button 0
    repeat (10) step(4'h0, "t6_clear");
    repeat (4) step(4'h1, "t6_count");
    reset = 1'b0;
    model_reset();
    #1;
    chk_zero("t6_rst");
    repeat (2) step(4'h1, "t6_inrst");
    reset = 1'b1;
    hold_until(4'h1, 4'h1, 1'b0, "t6", at, vec, anyv);
    chk("t6_latency", 32'(at), 32'd6);
    chk("t6_pressvec", 32'(vec), 32'h1);

    // Random phase: random hold lengths produce both bounces and valid presses; occasional resets.
    raw = 4'h0;
    hold = 0;
    for (int c = 0; c < 400; c++) begin
      if (hold == 0) begin
        raw = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 8);
      end
      hold--;
      if ($urandom_range(0, 79) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
        chk_zero("rnd_rst");
        step(raw, "rnd_inrst");
        reset = 1'b1;
      end
      step(raw, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
